// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared TX FSM encodings, status-word bit positions and the
//                baud divisor helper for the UART transmit path.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    localparam int ST_FULL      = 0;
    localparam int ST_BUSY      = 1;
    localparam int ST_OVF       = 2;
    localparam int ST_COUNT_LSB = 8;

    function automatic int calc_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock circular-buffer FIFO with occupancy count and
//                combinational head output.
//  Revision    : 1.0  initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    localparam int        C_DEPTH    = 1 << AW;
    localparam logic [AW:0] C_FULL_CNT = {1'b1, {AW{1'b0}}};

    logic [WIDTH-1:0] r_mem [C_DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == C_FULL_CNT);
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_pop  = pop & ~empty;
    // A push into a full FIFO is legal only when the head leaves on the same edge.
    assign w_do_push = push & (~full | w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_fifo
//  Description : IO-mapped UART transmitter: byte FIFO feeding an 8N1
//                serialiser, with a pollable status word for firmware.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 27000000,
    parameter int BAUD        = 115200,
    parameter int FIFO_AW     = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        uart_valid,
    input  logic [7:0]  uart_data,
    input  logic        status_rd,
    output logic [31:0] status_rdata,
    output logic        tx
);

    localparam int             C_DIV      = calc_div(CLK_FREQ_HZ, BAUD);
    localparam int             C_BW       = $clog2(C_DIV);
    localparam logic [C_BW-1:0] C_DIV_LAST = C_BW'(C_DIV - 1);

    logic [1:0]      r_state;
    logic [1:0]      w_state_next;
    logic [C_BW-1:0] r_baud;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;
    logic            r_tx;
    logic            r_overflow;

    logic            w_bit_end;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;
    logic            w_tx_next;
    logic [7:0]      w_head;
    logic [FIFO_AW:0] w_count;
    logic [7:0]      w_count8;
    logic            w_full;
    logic            w_empty;

    sync_fifo #(
        .WIDTH (8),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (w_push),
        .pop    (w_pop),
        .din    (uart_data),
        .dout   (w_head),
        .count  (w_count),
        .full   (w_full),
        .empty  (w_empty)
    );

    assign w_bit_end = (r_baud == C_DIV_LAST);
    assign w_drop    = uart_valid & w_full & ~w_pop;
    assign w_push    = uart_valid & ~w_drop;

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (!w_empty) w_state_next = START;
            START:   if (w_bit_end) w_state_next = DATA;
            DATA:    if (w_bit_end && r_bit_idx == 3'd7) w_state_next = STOP;
            STOP:    if (w_bit_end) w_state_next = w_empty ? IDLE : START;
            default: w_state_next = IDLE;
        endcase
    end

    // Output decode: pop strobe and the value tx takes on the next edge
    always_comb begin
        w_pop     = 1'b0;
        w_tx_next = r_tx;
        case (r_state)
            IDLE: begin
                w_pop     = ~w_empty;
                w_tx_next = w_empty;
            end
            START: begin
                if (w_bit_end) w_tx_next = r_shift[0];
            end
            DATA: begin
                if (w_bit_end) w_tx_next = (r_bit_idx == 3'd7) ? 1'b1 : r_shift[1];
            end
            STOP: begin
                if (w_bit_end) begin
                    w_pop     = ~w_empty;
                    w_tx_next = w_empty;
                end
            end
            default: w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_baud     <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            r_tx <= w_tx_next;

            if (r_state == IDLE || w_bit_end) begin
                r_baud <= '0;
            end else begin
                r_baud <= r_baud + C_BW'(1);
            end

            if (r_state != DATA) begin
                r_bit_idx <= '0;
            end else if (w_bit_end) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end

            if (w_pop) begin
                r_shift <= w_head;
            end else if (r_state == DATA && w_bit_end) begin
                r_shift <= {1'b0, r_shift[7:1]};
            end

            // A drop in the same cycle as a status read keeps the flag set.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (status_rd) begin
                r_overflow <= 1'b0;
            end
        end
    end

    generate
        if (FIFO_AW >= 7) begin : g_cnt_trunc
            assign w_count8 = w_count[7:0];
        end else begin : g_cnt_pad
            assign w_count8 = {{(7 - FIFO_AW){1'b0}}, w_count};
        end
    endgenerate

    always_comb begin
        status_rdata                        = '0;
        status_rdata[ST_FULL]               = w_full;
        status_rdata[ST_BUSY]               = (r_state != IDLE) | ~w_empty;
        status_rdata[ST_OVF]                = r_overflow;
        status_rdata[ST_COUNT_LSB +: 8]     = w_count8;
    end

    assign tx = r_tx;

endmodule
`default_nettype wire

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Downstream consumer of the core's IO write port.
- Takes the byte strobe the SOC decodes from IO word-address bit 1 (uart_valid), buffers it in a small FIFO, and serialises it as 8N1 on a TX pin.
- Returns a status word for the core's IO read path, so firmware can poll full/busy instead of relying on the simulation-only $write.

Parameters:
- CLK_FREQ_HZ, 27000000, frequency of clk in Hz.
- BAUD, 115200, line rate. DIV = CLK_FREQ_HZ / BAUD (integer floor; 234 at defaults). DIV must be >= 2.
- FIFO_AW, 4, FIFO address bits; depth = 2**FIFO_AW (16).

Ports:
- clk  in  1  system clock, all logic on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- uart_valid  in  1  one-cycle write strobe (IO_mem_wr & IO word-address bit 1).
- uart_data  in  8  byte to send (IO_mem_wdata[7:0]), sampled when uart_valid=1.
- status_rd  in  1  strobe: core is reading the status word this cycle.
- status_rdata  out  32  {16'b0, count[7:0], 5'b0, overflow, busy, full}; count is zero-extended.
- tx  out  1  serial output, idle high.

Behaviour:
Reset:
- resetn low immediately (asynchronously) forces: tx=1, FIFO empty (count=0), overflow=0, FSM=IDLE, baud counter=0, bit index=0.
- A frame in progress is abandoned; there is no partial stop bit.

Write path:
- A write is accepted iff count < 2**FIFO_AW, or the FSM pops in the same cycle.
- If a write arrives when full and there is no pop, the byte is dropped and overflow is set to 1 on that edge.
- overflow is sticky. It clears on the edge after a status_rd, unless a new drop occurs in the same cycle; set wins.

Status bits:
- full = (count == 2**FIFO_AW).
- busy = (FSM != IDLE) | (count != 0).
- status_rdata is combinational from registered state.

FIFO:
- Circular buffer with wr_ptr/rd_ptr of FIFO_AW bits that wrap modulo depth, plus a count of FIFO_AW+1 bits.
- Simultaneous push and pop leaves count unchanged.

TX FSM (states IDLE, START, DATA, STOP):
- IDLE: if count != 0, pop the head byte into the shift register, baud counter <= 0, go to START. tx stays registered at 1 during the IDLE cycle.
- START: tx=0 for DIV cycles.
- DATA: bits 0..7, LSB first, each held DIV cycles; the bit index advances 0..7.
- STOP: tx=1 for DIV cycles. Then, if count != 0, pop and go directly to START (back-to-back, no idle gap); otherwise go to IDLE.

Latency:
- Write sampled on edge k into an empty FIFO in IDLE: pop on edge k+1, tx falls after edge k+1 (tx is a registered output).
- Frame length is exactly 10*DIV cycles.

Baud counter:
- Counts 0..DIV-1 and wraps. Its width is clog2(DIV).
- The bit boundary is at DIV-1.

Decomposition:
- Shared package uart_pkg:
  - FSM state localparams (IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3).
  - Status bit positions (ST_FULL=0, ST_BUSY=1, ST_OVF=2, ST_COUNT_LSB=8).
- One sub-module, sync_fifo:
  - Parameters: width 8, address bits FIFO_AW.
  - Ports: push, pop, din, dout, count, full, empty.
  - Same async active-low reset.
- The top level holds the baud counter, TX FSM, shift register and overflow flag.

Test Plan:
Bench uses CLK_FREQ_HZ=1000000, BAUD=100000, so DIV=10 and a frame is 100 cycles.
1. Write 0x55 once from idle -> tx=1 until after the next edge, then low 10 cycles, then 1,0,1,0,1,0,1,0 (10 cycles each), then high 10 cycles. busy=1 for the duration, then busy=0 and status_rdata=0.
2. Write 0x41 then 0x42 on consecutive cycles -> two frames back-to-back with no idle gap; the 0x42 start bit begins exactly 100 cycles after the 0x41 start bit. count reads 1 after the first pop.
3. Write 18 bytes on consecutive cycles while idle -> first byte popped, 16 buffered, 1 dropped. full=1, overflow=1, count=16. status_rd strobe -> overflow=0 next cycle; full stays 1.
4. FIFO full and a write coinciding with the FSM pop at the end of a stop bit -> write accepted, count stays 16, overflow stays 0.
5. Assert resetn low at cycle 45 of a frame -> tx=1 immediately (asynchronously), status_rdata=0. After release with no writes, tx stays 1 and no further frame is emitted.
6. overflow set and status_rd in the same cycle as a new drop -> overflow remains 1.
